dl_rr_arbiter: RTL and testbench
================================

Name: dl_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-owner resource among N requesters, for example a dl_dff-based register bank or write port.
- Grants are registered and are held while the owner keeps requesting.
- An optional hold limit forces preemption so no requester can starve the others.
- Sits in design_lib beside dl_dff, for use by pipeline and bus control logic.

Parameters:
- N, 4: number of requesters; N ≥ 1.
- MAX_HOLD, 0: maximum consecutive cycles one owner may hold the grant; 0 = unlimited.
- IDX_W, max(1, $clog2(N)): width of the grant index (derived).
- CNT_W, max(1, $clog2(MAX_HOLD+1)): width of the hold counter (derived).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request vector; req[i] high = requester i wants or keeps the resource.
- gnt  out  N  one-hot grant, registered; all-zero when idle.
- gnt_vld  out  1  high iff gnt is non-zero.
- gnt_idx  out  IDX_W  binary index of the owner; meaningful only when gnt_vld=1.
- preempt  out  1  one-cycle pulse in the cycle a grant is forcibly moved because of the hold limit.

Behaviour:
- Reset (asynchronous, immediate, including mid-grant):
  - gnt=0, gnt_vld=0, gnt_idx=0, preempt=0.
  - State=ARB_IDLE, priority pointer ptr=0, hold_cnt=0.
- ptr is the first index searched. Picker: lowest i in the circular order ptr, ptr+1, …, N-1, 0, …, ptr-1 with req[i] & ~mask[i].
- ARB_IDLE:
  - If req≠0 (mask=0): the winner w is registered at the next edge (gnt[w]=1); ptr ← (w+1) mod N; hold_cnt ← 0; go to ARB_BUSY.
  - Latency: request visible at edge k → grant visible after edge k.
  - If req=0: stay idle.
- ARB_BUSY, owner o, evaluated each edge in priority order:
  1. Release (req[o]=0): pick among the others with mask=one-hot(o).
     - If a winner exists, hand off at this edge with no idle cycle; ptr ← w+1; hold_cnt ← 0.
     - Otherwise gnt ← 0 and go to ARB_IDLE.
  2. Timeout (MAX_HOLD≠0, req[o]=1, hold_cnt = MAX_HOLD-1): pick with mask=one-hot(o).
     - If a winner exists: hand off; preempt=1 for exactly the following cycle; ptr ← w+1; hold_cnt ← 0.
     - If no other requester: o keeps the grant, hold_cnt ← 0, preempt stays 0.
  3. Hold: otherwise hold_cnt ← hold_cnt+1, saturating at MAX_HOLD-1; gnt unchanged.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_idx matches gnt whenever gnt_vld=1.
  - gnt changes only at clock edges or on reset.
  - Requests that arrive for a non-owner while ARB_BUSY are simply pending; they are not latched. A req pulse that drops before being granted is lost.
- Wrap-around: ptr wraps N-1 → 0. With N not a power of two, pointer arithmetic is modulo N, never modulo 2^IDX_W.
- Degenerate cases:
  - N=1: gnt=req delayed one cycle; preempt never fires.
  - MAX_HOLD=1: handoff every cycle whenever others are requesting.
- X-safety: preempt and gnt are driven only from flops; there are no combinational paths from req to outputs.

Decomposition:
- Shared package dl_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e.
  - Function rr_next(idx, n) for modulo increment.
- Sub-module dl_rr_pick: purely combinational rotating-priority picker.
  - Inputs: req[N], mask[N], ptr[IDX_W].
  - Outputs: found, idx[IDX_W].
  - Parameter N. Reusable by later arbiters.
- Top level holds the FSM, ptr, the hold counter and the output registers.

Test Plan (N=4, MAX_HOLD=4 unless noted; bench uses the clk_intf generator and sim macros):
- Reset gating: rst_n=0 with req=4'b1111 → gnt=0, gnt_vld=0. Release rst_n; after the first edge gnt=4'b0001, gnt_idx=0.
- Fairness: all four requesters each hold 2 cycles, drop for 1, then re-request → grant order 0,1,2,3,0,1. No requester is skipped, and no gap appears while another requester is pending.
- Back-to-back handoff: owner 1; req[1] drops at edge k while req[3]=1 → after edge k gnt=4'b1000, gnt_idx=3, with no idle cycle.
- Preemption: req[2] held continuously with req[0]=1 → gnt=4'b0100 for exactly 4 cycles, then gnt=4'b0001 with preempt=1 for one cycle. With MAX_HOLD=0 the grant to 2 persists indefinitely.
- Sole requester at limit: only req[1]=1 for 12 cycles → gnt stays 4'b0010 throughout; preempt never asserts.
- Asynchronous reset mid-grant: owner 3; pull rst_n low between edges → gnt=0 and gnt_vld=0 immediately, without waiting for an edge. After release with req=4'b1010, the first grant goes to 1, because ptr was reset to 0.

Source files
------------

// File: rtl/dl_arb_pkg.sv
// Shared types and helpers for the design_lib arbiters.
// Anything the arbiters have in common lives here, so it does not have to be repeated in each one.
package dl_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // Modulo-n increment; n need not be a power of two.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dl_rr_pick.sv
// Combinational rotating-priority picker: first req[i] & ~mask[i] searching
// circularly from ptr. ptr is assumed to be < N.
module dl_rr_pick
  import dl_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int unsigned p;
    logic [IDX_W-1:0] pi;
    found = 1'b0;
    idx   = '0;
    p     = 0;
    pi    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      p = 32'(ptr) + k;
      if (p >= N) p = p - N;
      pi = IDX_W'(p);
      if (!found && req[pi] && !mask[pi]) begin
        found = 1'b1;
        idx   = pi;
      end
    end
  end

endmodule

// File: rtl/dl_rr_arbiter.sv
// Round-robin arbiter with registered, held grants and an optional hold limit
// that forces the grant onward when others are waiting.
module dl_rr_arbiter
  import dl_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             preempt
);

  localparam bit LIMITED = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = LIMITED ? CNT_W'(MAX_HOLD - 1) : '0;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             preempt_q, preempt_d;

  logic [N-1:0]     mask;
  logic             found;
  logic [IDX_W-1:0] win;
  logic             take;

  // Mask is kept in its own process so the picker result never feeds back
  // into the block that computes its input.
  always_comb begin
    mask = '0;
    if (state_q == ARB_BUSY) mask[idx_q] = 1'b1;
  end

  dl_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .mask  (mask),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    preempt_d = 1'b0;
    take      = 1'b0;

    case (state_q)
      ARB_IDLE: take = found;
      ARB_BUSY: begin
        if (!req[idx_q]) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (LIMITED && (hold_q == HOLD_LAST)) begin
          if (found) begin
            take      = 1'b1;
            preempt_d = 1'b1;
          end else begin
            hold_d = '0;
          end
        end else if (LIMITED) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (take) begin
      state_d    = ARB_BUSY;
      gnt_d      = '0;
      gnt_d[win] = 1'b1;
      idx_d      = win;
      ptr_d      = IDX_W'(rr_next(32'(win), N));
      hold_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = |gnt_q;
  assign gnt_idx = idx_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_dl_rr_arbiter.sv
// Directed bench for dl_rr_arbiter: N=4 with MAX_HOLD=4 and an unlimited twin.
module tb_dl_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b;
  logic       vld_a, vld_b;
  logic [1:0] idx_a, idx_b;
  logic       pre_a, pre_b;

  int unsigned n_vec;
  int unsigned n_err;

  dl_rr_arbiter #(
    .N        (4),
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt_a),
    .gnt_vld (vld_a),
    .gnt_idx (idx_a),
    .preempt (pre_a)
  );

  dl_rr_arbiter #(
    .N        (4),
    .MAX_HOLD (0)
  ) dut_nl (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt_b),
    .gnt_vld (vld_b),
    .gnt_idx (idx_b),
    .preempt (pre_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // Fairness vectors: each owner holds two cycles, drops for one, re-requests.
  logic [3:0] fair_req [12] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1111,
                                4'b1011, 4'b1111, 4'b0111, 4'b1111, 4'b1110, 4'b1111};
  logic [3:0] fair_gnt [12] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b1111;

    // Reset gating
    tick();
    tick();
    chk_val("rst_gnt", 32'(gnt_a), 32'h0);
    chk_val("rst_vld", 32'(vld_a), 32'h0);
    chk_val("rst_idx", 32'(idx_a), 32'h0);
    chk_val("rst_pre", 32'(pre_a), 32'h0);
    rst_n = 1'b1;
    tick();
    chk_val("first_gnt", 32'(gnt_a), 32'h1);
    chk_val("first_idx", 32'(idx_a), 32'h0);
    chk_val("first_vld", 32'(vld_a), 32'h1);

    // Fairness
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = fair_req[i];
      tick();
      chk_val($sformatf("fair_gnt%0d", i), 32'(gnt_a), 32'(fair_gnt[i]));
      chk_val($sformatf("fair_pre%0d", i), 32'(pre_a), 32'h0);
    end

    // Back-to-back handoff 1 -> 3
    do_reset();
    req = 4'b0010;
    tick();
    chk_val("b2b_own1", 32'(gnt_a), 32'h2);
    req = 4'b1000;
    tick();
    chk_val("b2b_gnt", 32'(gnt_a), 32'h8);
    chk_val("b2b_idx", 32'(idx_a), 32'h3);
    chk_val("b2b_vld", 32'(vld_a), 32'h1);

    // Preemption at the hold limit, unlimited twin keeps the grant
    do_reset();
    req = 4'b0100;
    tick();
    chk_val("pre_hold0", 32'(gnt_a), 32'h4);
    req = 4'b0101;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_val($sformatf("pre_hold%0d", i), 32'(gnt_a), 32'h4);
      chk_val($sformatf("pre_quiet%0d", i), 32'(pre_a), 32'h0);
    end
    tick();
    chk_val("pre_gnt", 32'(gnt_a), 32'h1);
    chk_val("pre_idx", 32'(idx_a), 32'h0);
    chk_val("pre_pulse", 32'(pre_a), 32'h1);
    tick();
    chk_val("pre_drop", 32'(pre_a), 32'h0);
    chk_val("pre_keep0", 32'(gnt_a), 32'h1);
    for (int i = 0; i < 6; i++) tick();
    chk_val("nl_gnt", 32'(gnt_b), 32'h4);
    chk_val("nl_pre", 32'(pre_b), 32'h0);

    // Sole requester at the limit
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_val($sformatf("sole_gnt%0d", i), 32'(gnt_a), 32'h2);
      chk_val($sformatf("sole_pre%0d", i), 32'(pre_a), 32'h0);
    end

    // Asynchronous reset mid-grant
    do_reset();
    req = 4'b1000;
    tick();
    tick();
    chk_val("ar_own3", 32'(gnt_a), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("ar_gnt", 32'(gnt_a), 32'h0);
    chk_val("ar_vld", 32'(vld_a), 32'h0);
    chk_val("ar_idx", 32'(idx_a), 32'h0);
    req = 4'b1010;
    tick();
    chk_val("ar_held", 32'(gnt_a), 32'h0);
    rst_n = 1'b1;
    tick();
    chk_val("ar_regnt", 32'(gnt_a), 32'h2);
    chk_val("ar_reidx", 32'(idx_a), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
